// File: rtl/hazard_controller_if.sv
// Hazard-control bundle between the ID/EX pipeline stages and the hazard controller.
// StallCount is present only when HAZ_PERF_CNT_EN is defined.
interface hazard_controller_if;
  logic [4:0]  ID_Rn;
  logic [4:0]  ID_Rm;
  logic        ID_UseRn;
  logic        ID_UseRm;
  logic        ID_IsMul;
  logic        ID_EX_MemRead;
  logic [4:0]  Rd_ID_EX;
  logic        EX_BranchTaken;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Bubble;
  logic        MulBusy;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] StallCount;

  modport master (
    output ID_Rn, ID_Rm, ID_UseRn, ID_UseRm, ID_IsMul, ID_EX_MemRead, Rd_ID_EX, EX_BranchTaken,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulBusy, StallCount
  );
  modport slave (
    input  ID_Rn, ID_Rm, ID_UseRn, ID_UseRm, ID_IsMul, ID_EX_MemRead, Rd_ID_EX, EX_BranchTaken,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulBusy, StallCount
  );
`else
  modport master (
    output ID_Rn, ID_Rm, ID_UseRn, ID_UseRm, ID_IsMul, ID_EX_MemRead, Rd_ID_EX, EX_BranchTaken,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulBusy
  );
  modport slave (
    input  ID_Rn, ID_Rm, ID_UseRn, ID_UseRm, ID_IsMul, ID_EX_MemRead, Rd_ID_EX, EX_BranchTaken,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulBusy
  );
`endif
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: branch flush, load-use stall, multi-cycle multiply stall.
// Optional stall-cycle performance counter enabled by defining HAZ_PERF_CNT_EN.
//
// state | meaning
// RUN   | normal issue; branch flush / load-use bubble / multiply entry decided here
// MUL   | front end frozen while the multiply completes; cnt counts remaining stalls
module hazard_controller #(
  parameter int unsigned MUL_LAT = 3
) (
  input logic           clk,
  input logic           reset,
  hazard_controller_if.slave haz
);

  typedef enum logic {S_RUN, S_MUL} state_t;

  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic       load_use;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_bubble;

  // X31 is the zero register, so a load targeting it never creates a dependency.
  assign load_use = haz.ID_EX_MemRead && (haz.Rd_ID_EX != 5'd31) &&
                    ((haz.ID_UseRn && (haz.ID_Rn == haz.Rd_ID_EX)) ||
                     (haz.ID_UseRm && (haz.ID_Rm == haz.Rd_ID_EX)));

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    state_next   = state;
    cnt_next     = cnt;
    if (state == S_MUL) begin
      // EX only holds bubbles here, so branch and load-use inputs are ignored.
      if (cnt != 4'd0) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        cnt_next     = cnt - 4'd1;
      end else begin
        state_next = S_RUN;
      end
    end else begin
      if (haz.EX_BranchTaken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (load_use) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end else if (haz.ID_IsMul) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        cnt_next     = MUL_CNT_INIT;
        state_next   = S_MUL;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  assign haz.PCWrite      = pc_write;
  assign haz.IF_ID_Write  = if_id_write;
  assign haz.IF_ID_Flush  = if_id_flush;
  assign haz.ID_EX_Bubble = id_ex_bubble;
  assign haz.MulBusy      = (state == S_MUL);

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 16'd0;
    end else if (!pc_write && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign haz.StallCount = stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: expected output vectors are queued as stimulus
// is applied and compared when the outputs are sampled mid-cycle.
module tb_hazard_controller;

  typedef struct packed {
    logic       br;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rn;
    logic [4:0] rm;
    logic       urn;
    logic       urm;
    logic       mul;
  } stim_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [4:0] exp_q[$];

  hazard_controller_if hif();

  hazard_controller #(.MUL_LAT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .haz   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(logic br, logic mr, logic [4:0] rd, logic [4:0] rn,
                               logic [4:0] rm, logic urn, logic urm, logic mul);
    stim_t s;
    s.br = br; s.mr = mr; s.rd = rd; s.rn = rn; s.rm = rm;
    s.urn = urn; s.urm = urm; s.mul = mul;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic drive(input stim_t s);
    hif.EX_BranchTaken = s.br;
    hif.ID_EX_MemRead  = s.mr;
    hif.Rd_ID_EX       = s.rd;
    hif.ID_Rn          = s.rn;
    hif.ID_Rm          = s.rm;
    hif.ID_UseRn       = s.urn;
    hif.ID_UseRm       = s.urm;
    hif.ID_IsMul       = s.mul;
  endtask

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulBusy}
  function automatic logic [4:0] outs();
    return {hif.PCWrite, hif.IF_ID_Write, hif.IF_ID_Flush, hif.ID_EX_Bubble, hif.MulBusy};
  endfunction

  task automatic test_reset();
    stim_t s[$];
    logic [4:0] e[$];
    logic r[$];
    logic [4:0] got, want;
    s.push_back(idle());                           e.push_back(5'b11000); r.push_back(1'b0);
    s.push_back(mk(0,0,0,1,2,0,0,1));              e.push_back(5'b00010); r.push_back(1'b0);
    s.push_back(mk(0,0,0,1,2,0,0,1));              e.push_back(5'b00010); r.push_back(1'b0);
    s.push_back(mk(0,0,0,1,2,0,0,1));              e.push_back(5'b00010); r.push_back(1'b1);
    s.push_back(mk(0,0,0,1,2,0,0,1));              e.push_back(5'b00011); r.push_back(1'b1);
    s.push_back(mk(0,0,0,1,2,0,0,1));              e.push_back(5'b00011); r.push_back(1'b1);
    s.push_back(mk(0,0,0,1,2,0,0,1));              e.push_back(5'b11001); r.push_back(1'b1);
    s.push_back(idle());                           e.push_back(5'b11000); r.push_back(1'b1);
    for (int i = 0; i < s.size(); i++) begin
      reset = r[i];
      drive(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = outs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL reset[%0d] got=%b want=%b", i, got, want);
      end
`ifdef HAZ_PERF_CNT_EN
      if (r[i] == 1'b0) begin
        checks++;
        if (hif.StallCount !== 16'd0) begin
          failures++;
          $display("FAIL reset_stallcount[%0d] got=%h want=0000", i, hif.StallCount);
        end
      end
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t s[$];
    logic [4:0] e[$];
    logic [4:0] got, want;
    s.push_back(mk(0,1,5,5,0,1,0,0));  e.push_back(5'b00010);
    s.push_back(idle());               e.push_back(5'b11000);
    s.push_back(mk(0,1,0,0,4,1,0,0));  e.push_back(5'b00010);
    s.push_back(mk(0,1,12,3,12,0,1,0)); e.push_back(5'b00010);
    s.push_back(idle());               e.push_back(5'b11000);
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = outs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL load_use[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_no_stall();
    stim_t s[$];
    logic [4:0] e[$];
    logic [4:0] got, want;
    s.push_back(mk(0,1,31,31,31,1,1,0)); e.push_back(5'b11000);
    s.push_back(mk(0,1,7,3,7,1,0,0));    e.push_back(5'b11000);
    s.push_back(mk(0,1,7,3,7,0,1,0));    e.push_back(5'b00010);
    s.push_back(mk(0,0,7,7,7,1,1,0));    e.push_back(5'b11000);
    s.push_back(mk(0,1,9,9,2,0,1,0));    e.push_back(5'b11000);
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = outs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL no_stall[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_priority();
    stim_t s[$];
    logic [4:0] e[$];
    logic [4:0] got, want;
    s.push_back(mk(1,1,5,5,0,1,0,1));  e.push_back(5'b11110);
    s.push_back(idle());               e.push_back(5'b11000);
    s.push_back(mk(1,0,0,1,2,0,0,0));  e.push_back(5'b11110);
    s.push_back(idle());               e.push_back(5'b11000);
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = outs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL branch_priority[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use_then_mul();
    stim_t s[$];
    logic [4:0] e[$];
    logic [4:0] got, want;
    s.push_back(mk(0,1,5,5,0,1,0,1));  e.push_back(5'b00010);
    s.push_back(mk(0,0,5,5,0,1,0,1));  e.push_back(5'b00010);
    s.push_back(mk(1,1,5,5,0,1,0,1));  e.push_back(5'b00011);
    s.push_back(mk(0,0,5,5,0,1,0,1));  e.push_back(5'b00011);
    s.push_back(mk(1,1,5,5,0,1,0,1));  e.push_back(5'b11001);
    s.push_back(idle());               e.push_back(5'b11000);
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = outs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL load_use_then_mul[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    logic [4:0] e[$];
    logic [4:0] got, want;
    for (int k = 0; k < 2; k++) begin
      s.push_back(mk(0,0,0,1,2,0,0,1)); e.push_back(5'b00010);
      s.push_back(mk(0,0,0,1,2,0,0,1)); e.push_back(5'b00011);
      s.push_back(mk(0,0,0,1,2,0,0,1)); e.push_back(5'b00011);
      s.push_back(mk(0,0,0,1,2,0,0,1)); e.push_back(5'b11001);
    end
    s.push_back(idle());               e.push_back(5'b11000);
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = outs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL back_to_back[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [4:0] got, want;
    drive(mk(0,0,0,1,2,0,0,1));
    exp_q.push_back(5'b00010);
    @(negedge clk);
    got = outs(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL reset_mid_mul_entry got=%b want=%b", got, want);
    end
    @(posedge clk); #1;
    exp_q.push_back(5'b00011);
    @(negedge clk);
    got = outs(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL reset_mid_mul_busy got=%b want=%b", got, want);
    end
    @(posedge clk); #1;
    // second MUL cycle: abort with an asynchronous reset
    drive(idle());
    reset = 1'b0;
    exp_q.push_back(5'b11000);
    #1;
    got = outs(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL reset_mid_mul_async got=%b want=%b", got, want);
    end
`ifdef HAZ_PERF_CNT_EN
    checks++;
    if (hif.StallCount !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_mul_stallcount got=%h want=0000", hif.StallCount);
    end
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(5'b11000);
      @(negedge clk);
      got = outs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL reset_mid_mul_after[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
`ifdef HAZ_PERF_CNT_EN
    drive(mk(0,1,5,5,0,1,0,0));
    @(posedge clk); #1;
    drive(idle());
    @(negedge clk);
    checks++;
    if (hif.StallCount !== 16'd1) begin
      failures++;
      $display("FAIL stallcount_one got=%h want=0001", hif.StallCount);
    end
    @(posedge clk); #1;
`endif
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic test_saturation();
    drive(mk(0,1,5,5,0,1,0,0));
    repeat (70000) @(posedge clk);
    #1;
    checks++;
    if (hif.StallCount !== 16'hFFFF) begin
      failures++;
      $display("FAIL saturation got=%h want=ffff", hif.StallCount);
    end
    checks++;
    if (hif.PCWrite !== 1'b0) begin
      failures++;
      $display("FAIL saturation_pcwrite got=%b want=0", hif.PCWrite);
    end
    drive(idle());
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    drive(idle());
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_no_stall();
    test_mul_seq();
    test_branch_priority();
    test_load_use_then_mul();
    test_back_to_back();
    test_reset_mid_mul();
`ifdef HAZ_PERF_CNT_EN
    test_saturation();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic test_mul_seq();
    stim_t s[$];
    logic [4:0] e[$];
    logic [4:0] got, want;
    s.push_back(idle());               e.push_back(5'b11000);
    s.push_back(mk(0,0,0,1,2,0,0,1));  e.push_back(5'b00010);
    s.push_back(mk(0,0,0,1,2,0,0,1));  e.push_back(5'b00011);
    s.push_back(mk(0,0,0,1,2,0,0,1));  e.push_back(5'b00011);
    s.push_back(mk(0,0,0,1,2,0,0,1));  e.push_back(5'b11001);
    s.push_back(idle());               e.push_back(5'b11000);
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = outs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL mul[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

endmodule
